control_unit: RTL and testbench

Hardwired Moore control unit that sequences the 32-bit bus datapath through instruction fetch, decode and execute. It drives every datapath strobe (register-file select/enable, bus-source enables, ALU op select, memory read/write) one control step per clock. It replaces the hand-driven control sequences used in datapath benches, so programs run from memory autonomously.

---
 rtl/control_unit.sv | 166 ++++++++++++++++
 tb/tb_control_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer driving the bus datapath through fetch, decode and execute.
// Defining CONTROL_UNIT_STOP_EN adds a `stop` input that parks the FSM in STOPPED at instruction boundaries.
module control_unit (
    input  logic       clk,
    input  logic       clear,
`ifdef CONTROL_UNIT_STOP_EN
    input  logic       stop,
`endif
    input  logic [4:0] opcode,
    output logic       PCout,
    output logic       Zlowout,
    output logic       MDRout,
    output logic       Cout,
    output logic       BAout,
    output logic       MARin,
    output logic       Zin,
    output logic       PCin,
    output logic       MDRin,
    output logic       IRin,
    output logic       Yin,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       IncPC,
    output logic       Read,
    output logic       Write,
    output logic       ADD,
    output logic       SUB,
    output logic       AND,
    output logic       OR,
    output logic       SHR,
    output logic       SHL,
    output logic       ROR,
    output logic       ROL,
    output logic       NEG,
    output logic       NOT,
    output logic       run,
    output logic       illegal
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
`ifdef CONTROL_UNIT_STOP_EN
        , STOPPED
`endif
    } state_t;

    state_t     state_q, state_d, go_t0;
    logic [4:0] op_q, op_d;
    logic       is_reg, is_imm, is_un, is_ldi, is_ld, is_st, is_mem, is_nop, is_halt, is_ill, alu_en;

`ifdef CONTROL_UNIT_STOP_EN
    assign go_t0 = stop ? STOPPED : T0;
`else
    assign go_t0 = T0;
`endif

    // Instruction class decode works off the latched opcode so outputs stay Moore.
    assign is_reg  = op_q >= 5'd3 && op_q <= 5'd10;
    assign is_imm  = op_q >= 5'd11 && op_q <= 5'd13;
    assign is_un   = op_q == 5'd16 || op_q == 5'd17;
    assign is_ldi  = op_q == 5'd1;
    assign is_ld   = op_q == 5'd0;
    assign is_st   = op_q == 5'd2;
    assign is_mem  = is_ld || is_st;
    assign is_nop  = op_q == 5'd26;
    assign is_halt = op_q == 5'd27;
    assign is_ill  = !(op_q <= 5'd13 || is_un || is_nop || is_halt);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE:    state_d = go_t0;
            T0:      state_d = T1;
            T1:      state_d = T2;
            T2: begin
                state_d = T3;
                op_d    = opcode;
            end
            T3:      state_d = is_halt ? HALT : (is_nop || is_ill) ? go_t0 : T4;
            T4:      state_d = is_un ? go_t0 : T5;
            T5:      state_d = is_mem ? T6 : go_t0;
            T6:      state_d = T7;
            T7:      state_d = go_t0;
            HALT:    state_d = HALT;
`ifdef CONTROL_UNIT_STOP_EN
            STOPPED: state_d = stop ? STOPPED : T0;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {PCout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin,
         Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, illegal, alu_en} = '0;
        run = 1'b1;
        case (state_q)
            T0: {PCout, MARin, IncPC, Zin} = '1;
            T1: {Zlowout, PCin, Read, MDRin} = '1;
            T2: {MDRout, IRin} = '1;
            T3: begin
                Grb     = !(is_nop || is_halt || is_ill);
                Rout    = is_reg || is_imm || is_un;
                Yin     = is_reg || is_imm || is_ldi || is_mem;
                BAout   = is_ldi || is_mem;
                Zin     = is_un;
                alu_en  = is_un;
                illegal = is_ill;
            end
            T4: begin
                Grc     = is_reg;
                Rout    = is_reg;
                Cout    = is_imm || is_ldi || is_mem;
                alu_en  = !is_un;
                Zin     = !is_un;
                Zlowout = is_un;
                Gra     = is_un;
                Rin     = is_un;
            end
            T5: begin
                Zlowout = 1'b1;
                MARin   = is_mem;
                Gra     = !is_mem;
                Rin     = !is_mem;
            end
            T6: begin
                MDRin = 1'b1;
                Read  = is_ld;
                Gra   = is_st;
                Rout  = is_st;
            end
            T7: begin
                MDRout = is_ld;
                Gra    = is_ld;
                Rin    = is_ld;
                Write  = is_st;
            end
            HALT:    run = 1'b0;
            default: ;
        endcase
    end

    // Address arithmetic for ld/ldi/st reuses the ADD unit.
    assign ADD = alu_en && (op_q == 5'd3 || op_q == 5'd11 || op_q <= 5'd2);
    assign SUB = alu_en && op_q == 5'd4;
    assign AND = alu_en && (op_q == 5'd5 || op_q == 5'd12);
    assign OR  = alu_en && (op_q == 5'd6 || op_q == 5'd13);
    assign SHR = alu_en && op_q == 5'd7;
    assign SHL = alu_en && op_q == 5'd8;
    assign ROR = alu_en && op_q == 5'd9;
    assign ROL = alu_en && op_q == 5'd10;
    assign NEG = alu_en && op_q == 5'd16;
    assign NOT = alu_en && op_q == 5'd17;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven latency checks plus randomized instruction streams against a step-list model.
module tb_control_unit;
    logic clk = 1'b0;
    logic clear = 1'b1;
    logic [4:0] opcode = '0;
`ifdef CONTROL_UNIT_STOP_EN
    logic stop = 1'b0;
`endif
    logic PCout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, run, illegal;
    logic [30:0] outs;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clear(clear),
`ifdef CONTROL_UNIT_STOP_EN
        .stop(stop),
`endif
        .opcode(opcode),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .run(run), .illegal(illegal)
    );

    assign outs = {PCout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin,
                   Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write,
                   ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, run, illegal};

    localparam logic [30:0] PCO = 31'd1 << 30, ZLO = 31'd1 << 29, MDO = 31'd1 << 28, CO = 31'd1 << 27;
    localparam logic [30:0] BAO = 31'd1 << 26, MAI = 31'd1 << 25, ZI = 31'd1 << 24, PCI = 31'd1 << 23;
    localparam logic [30:0] MDI = 31'd1 << 22, IRI = 31'd1 << 21, YIN = 31'd1 << 20, GRA = 31'd1 << 19;
    localparam logic [30:0] GRB = 31'd1 << 18, GRC = 31'd1 << 17, RIN = 31'd1 << 16, ROUT = 31'd1 << 15;
    localparam logic [30:0] INC = 31'd1 << 14, RD = 31'd1 << 13, WR = 31'd1 << 12, M_ADD = 31'd1 << 11;
    localparam logic [30:0] M_SUB = 31'd1 << 10, M_AND = 31'd1 << 9, M_OR = 31'd1 << 8, M_SHR = 31'd1 << 7;
    localparam logic [30:0] M_SHL = 31'd1 << 6, M_ROR = 31'd1 << 5, M_ROL = 31'd1 << 4, M_NEG = 31'd1 << 3;
    localparam logic [30:0] M_NOT = 31'd1 << 2, RUN = 31'd1 << 1, ILL = 31'd1;
    localparam logic [30:0] F0 = PCO | MAI | INC | ZI | RUN;
    localparam logic [30:0] F1 = ZLO | PCI | RD | MDI | RUN;
    localparam logic [30:0] F2 = MDO | IRI | RUN;

    int tests = 0;
    int fails = 0;
    logic [30:0] exp_q[$];

    typedef struct {
        logic [4:0] op;
        int len;
        int wr;
        int rd;
        int ill;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [30:0] alu_mask(input logic [4:0] op);
        case (op)
            5'd3, 5'd11: return M_ADD;
            5'd4:        return M_SUB;
            5'd5, 5'd12: return M_AND;
            5'd6, 5'd13: return M_OR;
            5'd7:        return M_SHR;
            5'd8:        return M_SHL;
            5'd9:        return M_ROR;
            5'd10:       return M_ROL;
            5'd16:       return M_NEG;
            5'd17:       return M_NOT;
            default:     return '0;
        endcase
    endfunction

    // Expected output per cycle after T0, written straight from the instruction step lists.
    function automatic void build(input logic [4:0] op);
        logic [30:0] a;
        a = alu_mask(op);
        exp_q.delete();
        exp_q.push_back(F1);
        exp_q.push_back(F2);
        if (op >= 5'd3 && op <= 5'd13) begin
            exp_q.push_back(GRB | ROUT | YIN);
            exp_q.push_back((op <= 5'd10 ? (GRC | ROUT) : CO) | a | ZI);
            exp_q.push_back(ZLO | GRA | RIN);
        end else if (op == 5'd16 || op == 5'd17) begin
            exp_q.push_back(GRB | ROUT | a | ZI);
            exp_q.push_back(ZLO | GRA | RIN);
        end else if (op <= 5'd2) begin
            exp_q.push_back(GRB | BAO | YIN);
            exp_q.push_back(CO | M_ADD | ZI);
            if (op == 5'd1) exp_q.push_back(ZLO | GRA | RIN);
            else begin
                exp_q.push_back(ZLO | MAI);
                exp_q.push_back(op == 5'd0 ? (RD | MDI) : (GRA | ROUT | MDI));
                exp_q.push_back(op == 5'd0 ? (MDO | GRA | RIN) : WR);
            end
        end else if (op == 5'd26 || op == 5'd27) exp_q.push_back('0);
        else exp_q.push_back(ILL);
        foreach (exp_q[i]) exp_q[i] = exp_q[i] | RUN;
        if (op == 5'd27) repeat (20) exp_q.push_back('0);
        else exp_q.push_back(F0);
    endfunction

    // Entered at a T0 negedge; checks up to n model steps (n<0 means all).
    task automatic run_steps(input logic [4:0] op, input int n);
        build(op);
        opcode = 5'($urandom);
        for (int k = 0; k < exp_q.size() && (n < 0 || k < n); k++) begin
            @(negedge clk);
            check($sformatf("op%0d_step%0d", op, k), outs, exp_q[k]);
            opcode = (k == 1) ? op : 5'($urandom);
        end
    endtask

    task automatic apply_clear(input string name);
        clear = 1'b1;
        #1 check({name, "_async"}, outs, RUN);
        @(negedge clk) check({name, "_hold"}, outs, RUN);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk) check({name, "_idle"}, outs, RUN);
        @(negedge clk) check({name, "_t0"}, outs, F0);
    endtask

    task automatic measure(input logic [4:0] op, output int len, output int wr, output int rd, output int il);
        len = 99;
        wr = 0;
        rd = 0;
        il = 0;
        opcode = 5'($urandom);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (outs === F0) begin
                len = c;
                break;
            end
            wr += int'(Write);
            rd += int'(Read);
            il += int'(illegal);
            opcode = (c == 2) ? op : 5'($urandom);
        end
    endtask

    initial begin
        int len, wr, rd, il;
        logic [4:0] op;
        tbl[0]  = '{5'd3, 6, 0, 1, 0};
        tbl[1]  = '{5'd4, 6, 0, 1, 0};
        tbl[2]  = '{5'd11, 6, 0, 1, 0};
        tbl[3]  = '{5'd16, 5, 0, 1, 0};
        tbl[4]  = '{5'd17, 5, 0, 1, 0};
        tbl[5]  = '{5'd1, 6, 0, 1, 0};
        tbl[6]  = '{5'd0, 8, 0, 2, 0};
        tbl[7]  = '{5'd2, 8, 1, 1, 0};
        tbl[8]  = '{5'd26, 4, 0, 1, 0};
        tbl[9]  = '{5'd30, 4, 0, 1, 1};
        tbl[10] = '{5'd14, 4, 0, 1, 1};
        tbl[11] = '{5'd18, 4, 0, 1, 1};

        for (int i = 0; i < 3; i++) @(negedge clk) check("reset", outs, RUN);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk) check("idle", outs, RUN);
        @(negedge clk) check("first_t0", outs, F0);

        for (int i = 0; i < 12; i++) begin
            measure(tbl[i].op, len, wr, rd, il);
            checki($sformatf("len_op%0d", tbl[i].op), len, tbl[i].len);
            checki($sformatf("write_op%0d", tbl[i].op), wr, tbl[i].wr);
            checki($sformatf("read_op%0d", tbl[i].op), rd, tbl[i].rd);
            checki($sformatf("illegal_op%0d", tbl[i].op), il, tbl[i].ill);
            if (len == 99) apply_clear("resync");
        end

        run_steps(5'd3, -1);
        run_steps(5'd0, -1);
        run_steps(5'd2, -1);
        run_steps(5'd30, -1);

        run_steps(5'd2, 6);
        apply_clear("clear_st_t6");

        run_steps(5'd27, -1);
        apply_clear("halt_clear");

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom);
            run_steps(op, -1);
            if (op == 5'd27) apply_clear("rand_halt");
        end

`ifdef CONTROL_UNIT_STOP_EN
        run_steps(5'd3, 5);
        stop = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk) check("stopped", outs, RUN);
        stop = 1'b0;
        @(negedge clk) check("stop_release_t0", outs, F0);
        run_steps(5'd4, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
